player_input: RTL

// Conditions the two raw player push-buttons for the tug-of-war playfield.

---
 rtl/player_input.sv | 73 +++++++
 1 files changed

// File: rtl/player_input.sv
// rtl/player_input.sv - two-button synchronizer, debounce and press one-shot with tie arbitration and freeze gate
module player_input #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic Reset,
    input  logic rawLeft,
    input  logic rawRight,
    input  logic freeze,
    output logic leftButton,
    output logic rightButton,
    output logic tie
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Channel index 0 = left, 1 = right; 1 = pressed after polarity normalisation.
    logic [1:0]    p;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    deb;
    logic [1:0]    ev;
    logic [CW-1:0] cnt [2];

    assign p = (ACTIVE_LOW != 0) ? ~{rawRight, rawLeft} : {rawRight, rawLeft};

    always_comb begin
        ev = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ev[i] = ~deb[i] & s2[i] & (cnt[i] == CNT_MAX);
        end
    end

    // Reset treats both buttons as pressed so a button held through reset cannot pulse.
    always_ff @(posedge clk) begin
        if (Reset) begin
            s1  <= 2'b11;
            s2  <= 2'b11;
            deb <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= p;
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            leftButton  <= 1'b0;
            rightButton <= 1'b0;
            tie         <= 1'b0;
        end else begin
            tie         <= ev[0] & ev[1] & ~freeze;
            leftButton  <= ev[0] & ~ev[1] & ~freeze;
            rightButton <= ev[1] & ~ev[0] & ~freeze;
        end
    end

endmodule
